// File: rtl/jk_excite_seq.sv
// Stimulus-side driver for a bank of external JK flops: turns each requested
// target word into one cycle of J/K excitation, then checks the returned Q.
module jk_excite_seq #(
    parameter int WIDTH  = 4,
    parameter int CNT_W  = 8,
    parameter int DC_ONE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt_data,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    input  logic [WIDTH-1:0] q_in,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    input  logic             err_clr
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRIVE = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;

    localparam logic             DC      = (DC_ONE != 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Inverse of the JK characteristic: each bit's don't-care resolves to DC.
    function automatic logic [WIDTH-1:0] exc_j(input logic [WIDTH-1:0] q,
                                               input logic [WIDTH-1:0] t);
        return (~q & t) | (q & {WIDTH{DC}});
    endfunction

    function automatic logic [WIDTH-1:0] exc_k(input logic [WIDTH-1:0] q,
                                               input logic [WIDTH-1:0] t);
        return (q & ~t) | (~q & {WIDTH{DC}});
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + 1'b1;
    endfunction

    logic [1:0]       state;
    logic [WIDTH-1:0] tgt_reg;
    logic             miss;

    assign tgt_ready = (state == IDLE);
    assign miss      = (state == CHECK) && (q_in != tgt_reg);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            tgt_reg <= '0;
            j_out   <= '0;
            k_out   <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done  <= 1'b0;
            err   <= 1'b0;
            j_out <= '0;
            k_out <= '0;
            case (state)
                IDLE: begin
                    if (tgt_valid) begin
                        tgt_reg <= tgt_data;
                        j_out   <= exc_j(q_in, tgt_data);
                        k_out   <= exc_k(q_in, tgt_data);
                        state   <= DRIVE;
                    end
                end
                DRIVE: state <= CHECK;
                CHECK: begin
                    done  <= 1'b1;
                    err   <= miss;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Counter moves on the same edge that raises err; a clear always wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if (miss) begin
            err_cnt <= sat_inc(err_cnt);
        end
    end

endmodule

// File: tb/tb_jk_excite_seq.sv
// Directed bench for jk_excite_seq with a behavioural JK flop bank on q_in.
module tb_jk_excite_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tgt_valid = 1'b0;
    logic [3:0] tgt_data = '0;
    logic       err_clr = 1'b0;
    logic [3:0] q_in;

    logic       tgt_ready, done, err;
    logic [3:0] j_out, k_out;
    logic [7:0] err_cnt;
    logic       tgt_ready1, done1, err1;
    logic [3:0] j_out1, k_out1;
    logic [7:0] err_cnt1;

    logic       q_force = 1'b1;
    logic [3:0] q_val = '0;
    logic [3:0] fq = '0;
    logic       fq_load = 1'b0;
    logic [3:0] fq_val = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Model of the external flop bank, driven by the DC_ONE=0 instance.
    always @(posedge clk) begin
        if (fq_load) fq <= fq_val;
        else         fq <= (j_out & ~fq) | (~k_out & fq);
    end

    assign q_in = q_force ? q_val : fq;

    jk_excite_seq #(.WIDTH(4), .CNT_W(8), .DC_ONE(0)) dut (
        .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready),
        .tgt_data(tgt_data), .j_out(j_out), .k_out(k_out), .q_in(q_in),
        .done(done), .err(err), .err_cnt(err_cnt), .err_clr(err_clr)
    );

    jk_excite_seq #(.WIDTH(4), .CNT_W(8), .DC_ONE(1)) dut1 (
        .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready1),
        .tgt_data(tgt_data), .j_out(j_out1), .k_out(k_out1), .q_in(q_in),
        .done(done1), .err(err1), .err_cnt(err_cnt1), .err_clr(err_clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preset_flops(input logic [3:0] v);
        fq_load = 1'b1;
        fq_val  = v;
        tick();
        fq_load = 1'b0;
    endtask

    // Presents one target while idle; returns just after the accepting edge.
    task automatic issue(input logic [3:0] d);
        tgt_valid = 1'b1;
        tgt_data  = d;
        tick();
        tgt_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({tgt_ready, j_out, k_out, done, err, err_cnt} !== {1'b1, 18'd0}) begin
            errors++;
            $display("FAIL reset_state ready=%b j=%b k=%b done=%b err=%b cnt=%0d want ready=1 rest 0",
                     tgt_ready, j_out, k_out, done, err, err_cnt);
        end
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single();
        q_force = 1'b0;
        preset_flops(4'b0000);
        issue(4'b1010);
        checks++;
        if ({j_out, k_out} !== {4'b1010, 4'b0000}) begin
            errors++;
            $display("FAIL single_jk j=%b k=%b want j=1010 k=0000", j_out, k_out);
        end
        tick();
        checks++;
        if ({j_out, k_out, tgt_ready, done} !== 10'd0) begin
            errors++;
            $display("FAIL single_drive_len j=%b k=%b ready=%b done=%b want all 0",
                     j_out, k_out, tgt_ready, done);
        end
        tick();
        checks++;
        if ({done, err, tgt_ready, err_cnt} !== {3'b101, 8'd0}) begin
            errors++;
            $display("FAIL single_done done=%b err=%b ready=%b cnt=%0d want 1 0 1 0",
                     done, err, tgt_ready, err_cnt);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse done=%b want 0", done);
        end
    endtask

    task automatic test_mixed();
        q_force = 1'b0;
        preset_flops(4'b1010);
        issue(4'b0110);
        checks++;
        if ({j_out, k_out} !== {4'b0100, 4'b1000}) begin
            errors++;
            $display("FAIL mixed_dc0 j=%b k=%b want j=0100 k=1000", j_out, k_out);
        end
        checks++;
        if ({j_out1, k_out1} !== {4'b1110, 4'b1101}) begin
            errors++;
            $display("FAIL mixed_dc1 j=%b k=%b want j=1110 k=1101", j_out1, k_out1);
        end
        tick();
        tick();
        checks++;
        if ({done, err, fq} !== {2'b10, 4'b0110}) begin
            errors++;
            $display("FAIL mixed_done done=%b err=%b q=%b want 1 0 0110", done, err, fq);
        end
    endtask

    task automatic test_mismatch();
        q_force = 1'b1;
        q_val   = 4'b0000;
        issue(4'b0011);
        checks++;
        if ({j_out, k_out} !== {4'b0011, 4'b0000}) begin
            errors++;
            $display("FAIL mismatch_jk j=%b k=%b want j=0011 k=0000", j_out, k_out);
        end
        tick();
        tick();
        checks++;
        if ({done, err, err_cnt} !== {2'b11, 8'd1}) begin
            errors++;
            $display("FAIL mismatch_first done=%b err=%b cnt=%0d want 1 1 1", done, err, err_cnt);
        end
        for (int i = 2; i <= 300; i++) begin
            issue(4'b0011);
            tick();
            tick();
            if (i == 255 || i == 256 || i == 300) begin
                checks++;
                if (err_cnt !== 8'd255 || err !== 1'b1) begin
                    errors++;
                    $display("FAIL saturate_%0d cnt=%0d err=%b want 255 1", i, err_cnt, err);
                end
            end
        end
    endtask

    task automatic test_clr_priority();
        q_force = 1'b1;
        q_val   = 4'b0000;
        issue(4'b0011);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if ({done, err, err_cnt} !== {2'b11, 8'd0}) begin
            errors++;
            $display("FAIL clr_priority done=%b err=%b cnt=%0d want 1 1 0", done, err, err_cnt);
        end
        issue(4'b0011);
        tick();
        tick();
        checks++;
        if (err_cnt !== 8'd1) begin
            errors++;
            $display("FAIL clr_recount cnt=%0d want 1", err_cnt);
        end
    endtask

    task automatic test_reset_mid_drive();
        q_force = 1'b1;
        q_val   = 4'b0000;
        issue(4'b1010);
        checks++;
        if (j_out !== 4'b1010 || tgt_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_pre j=%b ready=%b want 1010 0", j_out, tgt_ready);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({tgt_ready, j_out, k_out, done, err_cnt} !== {1'b1, 17'd0}) begin
            errors++;
            $display("FAIL rst_async ready=%b j=%b k=%b done=%b cnt=%0d want 1 0 0 0 0",
                     tgt_ready, j_out, k_out, done, err_cnt);
        end
        tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (done !== 1'b0 || tgt_ready !== 1'b1) begin
                errors++;
                $display("FAIL rst_no_done cyc=%0d done=%b ready=%b want 0 1", i, done, tgt_ready);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] tv [3];
        logic [7:0] exp_jk [3];
        int ndone;
        tv     = '{4'b0001, 4'b0010, 4'b0100};
        exp_jk = '{8'b0001_0000, 8'b0010_0001, 8'b0100_0010};
        ndone  = 0;
        q_force = 1'b0;
        preset_flops(4'b0000);
        tgt_valid = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tgt_data = tv[n];
            checks++;
            if (tgt_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready_idle n=%0d ready=%b want 1", n, tgt_ready);
            end
            tick();
            tgt_data = 4'b1111;
            checks++;
            if (tgt_ready !== 1'b0 || {j_out, k_out} !== exp_jk[n]) begin
                errors++;
                $display("FAIL b2b_drive n=%0d ready=%b jk=%b want 0 %b",
                         n, tgt_ready, {j_out, k_out}, exp_jk[n]);
            end
            tick();
            checks++;
            if (tgt_ready !== 1'b0 || done !== 1'b0 || {j_out, k_out} !== 8'd0) begin
                errors++;
                $display("FAIL b2b_check n=%0d ready=%b done=%b jk=%b want 0 0 0",
                         n, tgt_ready, done, {j_out, k_out});
            end
            tick();
            if (done === 1'b1) ndone++;
            checks++;
            if (done !== 1'b1 || err !== 1'b0 || fq !== tv[n]) begin
                errors++;
                $display("FAIL b2b_done n=%0d done=%b err=%b q=%b want 1 0 %b",
                         n, done, err, fq, tv[n]);
            end
        end
        tgt_valid = 1'b0;
        tick();
        checks++;
        if (done !== 1'b0 || ndone != 3) begin
            errors++;
            $display("FAIL b2b_count done=%b ndone=%0d want 0 3", done, ndone);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_mixed();
        test_mismatch();
        test_clr_priority();
        test_reset_mid_drive();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
